// File: rtl/sram_l0_loader.sv
// sram_l0_loader
// Read-side sequencer that streams num_words consecutive SRAM words into the L0 row buffer.
// A 2-stage valid pipe tracks the 1-cycle SRAM read latency and a small skid FIFO absorbs
// L0 backpressure. A new read is issued only while reads in flight plus skid occupancy
// leave room, so the FIFO can never overflow.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start, base_addr,    command strobe (sampled in IDLE) with first address and word count
//   num_words
//   busy, done           busy in ISSUE/DRAIN, done is a 1-cycle pulse in DONE
//   sram_cen, sram_wen,  SRAM read port (active-low enables, registered address)
//   sram_a, sram_q
//   l0_wr, l0_din,       L0 write port; a write is accepted on an edge where l0_wr & !l0_full
//   l0_full
module sram_l0_loader #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned SKID_DEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  output logic              l0_wr,
  output logic [DATA_W-1:0] l0_din,
  input  logic              l0_full
);

  localparam int unsigned PtrW = $clog2(SKID_DEP);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     num_q;
  logic [ADDR_W:0]     issue_cnt_q;
  logic [ADDR_W:0]     pop_cnt_q;
  logic                rd_v1_q;   // read registered on the last edge; SRAM samples it next edge
  logic                rd_v2_q;   // sram_q valid this cycle; pushed on the coming edge
  logic [DATA_W-1:0]   skid_mem [SKID_DEP];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     skid_cnt_q;

  logic                push;
  logic                pop;
  logic                accept_go;
  logic                issue_now;
  logic                issue_d;
  logic                credit_ok;
  logic [CntW:0]       occ;

  always_comb begin
    push      = rd_v2_q;
    pop       = (skid_cnt_q != '0) && !l0_full;
    // Occupancy after this edge if no new read were issued.
    occ       = {1'b0, skid_cnt_q} + {{CntW{1'b0}}, rd_v1_q} + {{CntW{1'b0}}, rd_v2_q}
              - {{CntW{1'b0}}, pop};
    credit_ok = occ < (CntW + 1)'(SKID_DEP);
    accept_go = (state_q == StIdle) && start && (num_words != '0);
    issue_now = (state_q == StIssue) && (issue_cnt_q != num_q) && credit_ok;
    issue_d   = accept_go || issue_now;
  end

  assign busy     = (state_q == StIssue) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign sram_wen = 1'b1;
  assign l0_wr    = (skid_cnt_q != '0);
  assign l0_din   = skid_mem[rd_ptr_q];

  // Control FSM with registered SRAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      num_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      sram_cen    <= 1'b1;
      sram_a      <= '0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
    end else begin
      sram_cen <= !issue_d;
      rd_v1_q  <= issue_d;
      rd_v2_q  <= rd_v1_q;
      if (pop) pop_cnt_q <= pop_cnt_q + (ADDR_W + 1)'(1);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_words != '0) begin
              state_q     <= StIssue;
              num_q       <= num_words;
              sram_a      <= base_addr;
              issue_cnt_q <= (ADDR_W + 1)'(1);
              pop_cnt_q   <= '0;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StIssue: begin
          if (issue_now) begin
            sram_a      <= sram_a + ADDR_W'(1);
            issue_cnt_q <= issue_cnt_q + (ADDR_W + 1)'(1);
            if (issue_cnt_q + (ADDR_W + 1)'(1) == num_q) state_q <= StDrain;
          end else if (issue_cnt_q == num_q) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // All reads issued, so every word has been pushed and popped once the count matches.
          if (pop_cnt_q == num_q) state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Skid FIFO pointers and count; push and pop may coincide at any fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + CntW'(1);
        2'b01:   skid_cnt_q <= skid_cnt_q - CntW'(1);
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr_q] <= sram_q;
  end

endmodule

// File: tb/tb_sram_l0_loader.sv
module tb_sram_l0_loader;

  localparam int AW = 11;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, sram_cen, sram_wen, l0_wr;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] l0_din;
  logic          l0_full = 1'b0;

  sram_l0_loader #(.ADDR_W(AW), .DATA_W(DW), .SKID_DEP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .l0_wr     (l0_wr),
    .l0_din    (l0_din),
    .l0_full   (l0_full)
  );

  always #5 clk = ~clk;

  // SRAM model: samples the registered request on an edge, data valid the following cycle.
  logic [DW-1:0] mem [2048];
  always @(posedge clk) if (!sram_cen && sram_wen) sram_q <= mem[sram_a];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Backpressure pattern: 3 cycles full, 2 cycles not full.
  bit bp_en = 1'b0;
  int bp_phase = 0;
  always @(posedge clk) begin
    #1;
    l0_full = bp_en ? (bp_phase < 3) : 1'b0;
    bp_phase = (bp_phase + 1) % 5;
  end

  // Monitor, sampled mid-cycle.
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] got_addr[$];
  int            pop_cyc[$];
  int issued, popped, max_occ, done_cnt, done_cyc, first_wr_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_cen) begin
        got_addr.push_back(sram_a);
        issued++;
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (l0_wr && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (l0_wr && !l0_full) begin
        got_data.push_back(l0_din);
        pop_cyc.push_back(cyc + 1);
        popped++;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic clear_mon();
    got_data.delete();
    got_addr.delete();
    pop_cyc.delete();
    issued = 0; popped = 0; max_occ = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, output int s);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n; s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); num_words = (AW + 1)'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference word k of a transfer starting at b: address wraps modulo 2048.
  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] b, input int k);
    logic [AW-1:0] a;
    a = b + AW'(k);
    return mem[a];
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_tests++; if (sram_cen !== 1'b1) begin n_fail++; $display("FAIL rst_cen got %b want 1", sram_cen); end
    n_tests++; if (sram_wen !== 1'b1) begin n_fail++; $display("FAIL rst_wen got %b want 1", sram_wen); end
    n_tests++; if (sram_a !== '0) begin n_fail++; $display("FAIL rst_a got %0d want 0", sram_a); end
    n_tests++; if (l0_wr !== 1'b0) begin n_fail++; $display("FAIL rst_l0wr got %b want 0", l0_wr); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (sram_cen !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst cen=%b busy=%b want 1/0", sram_cen, busy);
    end
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    for (int i = 0; i < 8; i++) mem[i] = DW'(i) * {8{16'h1111}};
    clear_mon();
    do_start(AW'(0), (AW + 1)'(8), s);
    wait_done(60, ok);
    repeat (4) @(posedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    n_tests++; if (got_data.size() != 8) begin
      n_fail++; $display("FAIL basic_count got %0d want 8", got_data.size());
    end
    for (int k = 0; k < 8 && k < got_data.size(); k++) begin
      n_tests++; if (got_data[k] !== exp_word(AW'(0), k)) begin
        n_fail++; $display("FAIL basic_data[%0d] got %h want %h", k, got_data[k], exp_word(AW'(0), k));
      end
      n_tests++; if (pop_cyc[k] != s + 3 + k) begin
        n_fail++; $display("FAIL basic_pop_cyc[%0d] got %0d want %0d", k, pop_cyc[k], s + 3 + k);
      end
    end
    n_tests++; if (first_wr_cyc != s + 2) begin
      n_fail++; $display("FAIL basic_first_wr got %0d want %0d", first_wr_cyc, s + 2);
    end
    n_tests++; if (done_cyc != s + 11) begin
      n_fail++; $display("FAIL basic_done_cyc got %0d want %0d", done_cyc, s + 11);
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int s, errs;
    bit ok;
    logic [AW-1:0] b;
    b = AW'($urandom);
    clear_mon();
    bp_en = 1'b1;
    do_start(b, (AW + 1)'(16), s);
    wait_done(300, ok);
    bp_en = 1'b0;
    repeat (4) @(posedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no done want done"); end
    n_tests++; if (got_data.size() != 16) begin
      n_fail++; $display("FAIL bp_count got %0d want 16", got_data.size());
    end
    errs = 0;
    for (int k = 0; k < got_data.size() && k < 16; k++) if (got_data[k] !== exp_word(b, k)) errs++;
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL bp_data got %0d bad words want 0", errs); end
    errs = 0;
    for (int k = 0; k < got_addr.size(); k++) if (got_addr[k] !== b + AW'(k)) errs++;
    n_tests++; if (got_addr.size() != 16 || errs != 0) begin
      n_fail++; $display("FAIL bp_addr got %0d reads %0d bad want 16 reads 0 bad", got_addr.size(), errs);
    end
    n_tests++; if (max_occ != 4) begin
      n_fail++; $display("FAIL bp_credit got max outstanding %0d want 4", max_occ);
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    int s;
    bit ok;
    logic [AW-1:0] want_a;
    clear_mon();
    do_start(AW'(2045), (AW + 1)'(5), s);
    wait_done(60, ok);
    repeat (3) @(posedge clk);
    n_tests++; if (!ok || got_addr.size() != 5 || got_data.size() != 5) begin
      n_fail++; $display("FAIL wrap_count got done=%0b reads=%0d words=%0d want 1/5/5",
                         ok, got_addr.size(), got_data.size());
    end
    for (int k = 0; k < 5 && k < got_addr.size() && k < got_data.size(); k++) begin
      want_a = AW'((2045 + k) % 2048);
      n_tests++; if (got_addr[k] !== want_a) begin
        n_fail++; $display("FAIL wrap_addr[%0d] got %0d want %0d", k, got_addr[k], want_a);
      end
      n_tests++; if (got_data[k] !== mem[want_a]) begin
        n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", k, got_data[k], mem[want_a]);
      end
    end
  endtask

  task automatic test_zero_ignore();
    int s, errs;
    bit ok;
    logic [AW-1:0] b;
    clear_mon();
    do_start(AW'($urandom), '0, s);
    repeat (4) @(posedge clk);
    #2;
    n_tests++; if (done_cnt != 1 || done_cyc != s) begin
      n_fail++; $display("FAIL zero_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, s);
    end
    n_tests++; if (issued != 0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", issued); end
    b = AW'($urandom);
    clear_mon();
    do_start(b, (AW + 1)'(6), s);
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", busy); end
    start = 1'b1; base_addr = b + AW'(500); num_words = (AW + 1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, ok);
    repeat (8) @(posedge clk);
    errs = 0;
    for (int k = 0; k < got_data.size() && k < 6; k++) if (got_data[k] !== exp_word(b, k)) errs++;
    n_tests++; if (!ok || got_data.size() != 6 || errs != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL ign_xfer got done=%0d words=%0d bad=%0d want 1/6/0",
                         done_cnt, got_data.size(), errs);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    clear_mon();
    do_start(AW'($urandom), (AW + 1)'(10), s);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (got_data.size() >= 3) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_progress got %0d words want 3", got_data.size()); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 ||
                   sram_a !== '0 || l0_wr !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs got busy=%b done=%b cen=%b wen=%b a=%0d wr=%b want 0/0/1/1/0/0",
                         busy, done, sram_cen, sram_wen, sram_a, l0_wr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    n_tests++; if (done_cnt != 0 || got_data.size() != 3) begin
      n_fail++; $display("FAIL rmid_quiet got done=%0d words=%0d want 0/3", done_cnt, got_data.size());
    end
    clear_mon();
    do_start(AW'(100), (AW + 1)'(2), s);
    wait_done(40, ok);
    repeat (8) @(posedge clk);
    n_tests++; if (!ok || got_data.size() != 2 || done_cnt != 1) begin
      n_fail++; $display("FAIL rmid_fresh_count got done=%0d words=%0d want 1/2", done_cnt, got_data.size());
    end
    for (int k = 0; k < 2 && k < got_data.size(); k++) begin
      n_tests++; if (got_data[k] !== mem[100 + k]) begin
        n_fail++; $display("FAIL rmid_fresh_data[%0d] got %h want %h", k, got_data[k], mem[100 + k]);
      end
    end
  endtask

  task automatic test_full();
    int s, derr, aerr;
    bit ok;
    logic [AW-1:0] b;
    b = AW'($urandom);
    clear_mon();
    do_start(b, (AW + 1)'(2048), s);
    wait_done(2300, ok);
    repeat (4) @(posedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
    n_tests++; if (got_data.size() != 2048 || got_addr.size() != 2048) begin
      n_fail++; $display("FAIL full_count got words=%0d reads=%0d want 2048/2048",
                         got_data.size(), got_addr.size());
    end
    derr = 0; aerr = 0;
    for (int k = 0; k < got_data.size() && k < 2048; k++) if (got_data[k] !== exp_word(b, k)) derr++;
    for (int k = 0; k < got_addr.size() && k < 2048; k++) if (got_addr[k] !== b + AW'(k)) aerr++;
    n_tests++; if (derr != 0 || aerr != 0) begin
      n_fail++; $display("FAIL full_order got %0d bad words %0d bad addrs want 0/0", derr, aerr);
    end
    n_tests++; if (done_cnt != 1 || done_cyc != s + 2048 + 3) begin
      n_fail++; $display("FAIL full_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, s + 2051);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_ignore();
    test_reset_mid();
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
